// File: rtl/decoder_2to4_sync.sv
// 2-to-4 one-hot decoder with combinational and registered outputs,
// plus per-line saturating hit counters for decode monitoring.
module decoder_2to4_sync #(
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         in,
  input  logic               clr_cnt,
  output logic [3:0]         out,
  output logic [3:0]         out_q,
  output logic               valid_q,
  output logic [4*CNT_W-1:0] hit_cnt
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [3:0]       out_q_d;
  logic             valid_q_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  always_comb begin
    out = 4'b0000;
    if (en) begin
      out = 4'b0001 << in;
    end
  end

  always_comb begin
    out_q_d   = out;
    valid_q_d = en;
  end

  // Clear wins over increment; a saturated line simply holds.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clr_cnt) begin
        cnt_d[k] = '0;
      end else if (en && (in == 2'(k)) && (cnt_q[k] != CntMax)) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= 4'b0000;
      valid_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      out_q   <= out_q_d;
      valid_q <= valid_q_d;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign hit_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_decoder_2to4_sync.sv
// Scoreboard bench for decoder_2to4_sync; runs an 8-bit and a 2-bit counter
// instance on identical stimulus against a behavioural model.
module tb_decoder_2to4_sync;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  sel;
  logic        clr;
  logic [3:0]  out8, out_q8, out2, out_q2;
  logic        valid_q8, valid_q2;
  logic [31:0] hit8;
  logic [7:0]  hit2;

  int n_tests;
  int n_fail;

  typedef struct packed {
    logic [3:0]  oq;
    logic        v;
    logic [31:0] h8;
    logic [7:0]  h2;
  } exp_t;

  exp_t sb_q[$];
  int   m8[4];
  int   m2[4];

  decoder_2to4_sync #(.CNT_W(8)) u_dut8 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in      (sel),
    .clr_cnt (clr),
    .out     (out8),
    .out_q   (out_q8),
    .valid_q (valid_q8),
    .hit_cnt (hit8)
  );

  decoder_2to4_sync #(.CNT_W(2)) u_dut2 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in      (sel),
    .clr_cnt (clr),
    .out     (out2),
    .out_q   (out_q2),
    .valid_q (valid_q2),
    .hit_cnt (hit2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, check the combinational path, predict the
  // registered state, then compare after the edge.
  task automatic step(input logic e, input logic [1:0] s, input logic c, input logic r);
    exp_t       x;
    logic [3:0] oc;
    en  = e;
    sel = s;
    clr = c;
    rst = r;
    #1;
    oc = e ? (4'b0001 << s) : 4'b0000;
    check_eq("out8", {28'd0, out8}, {28'd0, oc});
    check_eq("out2", {28'd0, out2}, {28'd0, oc});
    for (int k = 0; k < 4; k++) begin
      if (r || c) begin
        m8[k] = 0;
        m2[k] = 0;
      end else if (e && (int'(s) == k)) begin
        if (m8[k] < 255) m8[k]++;
        if (m2[k] < 3) m2[k]++;
      end
    end
    x.oq = r ? 4'b0000 : oc;
    x.v  = r ? 1'b0 : e;
    for (int k = 0; k < 4; k++) begin
      x.h8[k*8 +: 8] = 8'(m8[k]);
      x.h2[k*2 +: 2] = 2'(m2[k]);
    end
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb_q.pop_front();
      check_eq("out_q8", {28'd0, out_q8}, {28'd0, x.oq});
      check_eq("out_q2", {28'd0, out_q2}, {28'd0, x.oq});
      check_eq("valid_q8", {31'd0, valid_q8}, {31'd0, x.v});
      check_eq("valid_q2", {31'd0, valid_q2}, {31'd0, x.v});
      check_eq("hit8", hit8, x.h8);
      check_eq("hit2", {24'd0, hit2}, {24'd0, x.h2});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int k = 0; k < 4; k++) begin
      m8[k] = 0;
      m2[k] = 0;
    end
    rst = 1'b1;
    en  = 1'b0;
    sel = 2'd0;
    clr = 1'b0;
    @(posedge clk);
    #1;

    step(1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b1);
    // Counter accumulation and 2-bit saturation
    for (int i = 0; i < 5; i++) step(1'b1, 2'd3, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b1, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b1, 1'b1);
    // en toggling and select changes while disabled
    for (int i = 0; i < 8; i++) step(1'(i % 2), 2'(i % 4), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 2'(i), 1'b0, 1'b0);
    // Drive the 8-bit line 2 counter into saturation
    for (int i = 0; i < 262; i++) step(1'b1, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 120; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 29) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_2to4_sync.md
Name: decoder_2to4_sync

Overview:
2-to-4 one-hot decoder with active-high enable. Provides a purely combinational decoded output plus a registered copy with a valid flag. Provides per-line saturating hit counters for address-decode monitoring. Sits in front of 4-way select logic (chip-selects, mux controls) wherever a decoded strobe and usage statistics are needed.

Parameters:
CNT_W, 8, width of each per-line hit counter (legal range 1..32)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  decode enable
in  input  2  select code
clr_cnt  input  1  synchronous clear of all hit counters
out  output  4  combinational one-hot decode
out_q  output  4  registered decode, one cycle after sampling
valid_q  output  1  registered copy of en
hit_cnt  output  4*CNT_W  packed counters; line k at bits [k*CNT_W +: CNT_W]

Behaviour:
Interface: one clock; reset is synchronous and active-high (clk, rst).

Combinational path:
- out = 4'b0001 << in when en=1; out = 4'b0000 when en=0.
- Mapping: in=0 -> 0001, in=1 -> 0010, in=2 -> 0100, in=3 -> 1000.
- Not affected by clk, rst or clr_cnt; settles within the same delta/time step as an input change.
- X/Z on en or in is not required to be resolved; with legal inputs, out is never X.

Registered path:
- On each rising clk with rst=0: out_q <= out; valid_q <= en.
- Latency is exactly 1 cycle from en/in to out_q/valid_q.
- out_q is always either 0000 or exactly one-hot.
- out_q != 0 if and only if valid_q = 1.

Hit counters:
- On a rising clk with rst=0 and clr_cnt=0, if en=1, counter[in] increments by 1; the other counters hold.
- When en=0, all counters hold.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clr_cnt=1 at a clock edge sets all counters to 0. No increment happens that cycle, even if en=1.

Reset:
- rst=1 at a rising clk: out_q=0000, valid_q=0, all hit_cnt=0.
- rst has priority over clr_cnt and en.
- Reset asserted mid-operation takes effect at the next edge only. There is no asynchronous effect.
- The combinational out keeps following en/in during reset.

Boundary conditions:
- en toggling every cycle: the registered path tracks it cycle by cycle with no hold-over.
- in changing while en=0: no counter change; out_q stays 0000.
- Saturated counter with en=1 on that line: value holds at the maximum.

Test Plan:
- en=0, in=00, settle 1 time unit -> out=0000. After one clk: out_q=0000, valid_q=0, counters unchanged.
- en=1, sweep in=0..3, settle each step -> out=0001, 0010, 0100, 1000. One clk after each step, out_q matches and valid_q=1.
- Assert rst for one cycle with en=1, in=2 -> out_q=0000, valid_q=0, hit_cnt=0. Meanwhile out=0100 combinationally.
- Apply en=1 with in=3 for 5 cycles, then in=0 for 2 cycles (CNT_W=8) -> hit_cnt line3=5, line0=2, lines1/2=0.
- With CNT_W=2, apply en=1, in=1 for 6 cycles -> line1 counter saturates at 3 and stays 3.
- With counters non-zero, assert clr_cnt=1 with en=1, in=2 -> all counters 0 next cycle and line2 not incremented. Repeat with clr_cnt and rst asserted together -> reset result, all registers 0.
